// File: rtl/data_memory_subword_if.sv
// Request/response bus between the MEM stage (master) and the sub-word data memory (slave).
interface data_memory_subword_if;
  logic        Req_Valid_i;
  logic        Req_Ready_o;
  logic        Mem_Write_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Address_i;
  logic [31:0] Write_Data_i;
  logic        Resp_Valid_o;
  logic        Resp_Ready_i;
  logic [31:0] Read_Data_o;
  logic        Fault_o;

  modport master (
    output Req_Valid_i, Mem_Write_i, Funct3_i, Address_i, Write_Data_i, Resp_Ready_i,
    input  Req_Ready_o, Resp_Valid_o, Read_Data_o, Fault_o
  );

  modport slave (
    input  Req_Valid_i, Mem_Write_i, Funct3_i, Address_i, Write_Data_i, Resp_Ready_i,
    output Req_Ready_o, Resp_Valid_o, Read_Data_o, Fault_o
  );
endinterface

// File: rtl/data_memory_subword.sv
// RV32 data memory: byte/half/word loads and stores with extension, registered
// one-cycle load response under valid/ready backpressure, and access-fault detection.
module data_memory_subword #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input logic                  clk,
  input logic                  reset,
  data_memory_subword_if.slave bus
);

  localparam int unsigned AW = $clog2(MEMORY_DEPTH);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_resp_fault;
  logic                  r_store_fault;

  logic [31:0]           w_offset;
  logic [AW-1:0]         w_word_idx;
  logic                  w_in_range;
  logic                  w_align_ok;
  logic                  w_funct_ok;
  logic                  w_fault;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rd_word;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [31:0]           w_load_data;
  logic                  w_resp_valid;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_store_en;

  assign w_offset   = bus.Address_i - BASE_ADDR;
  assign w_word_idx = w_offset[AW+1:2];
  assign w_in_range = (w_offset[31:AW+2] == '0);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_align_ok = 1'b1;
    w_funct_ok = 1'b1;
    case (bus.Funct3_i)
      F3_B:    w_align_ok = 1'b1;
      F3_H:    w_align_ok = ~w_offset[0];
      F3_W:    w_align_ok = (w_offset[1:0] == 2'b00);
      F3_BU:   w_funct_ok = ~bus.Mem_Write_i;
      F3_HU: begin
        w_funct_ok = ~bus.Mem_Write_i;
        w_align_ok = ~w_offset[0];
      end
      default: w_funct_ok = 1'b0;
    endcase
    w_fault = ~w_in_range | ~w_align_ok | ~w_funct_ok;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.Write_Data_i;
    case (bus.Funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_offset[1:0];
        w_wdata = {4{bus.Write_Data_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_offset[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.Write_Data_i[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  assign w_rd_word = r_mem[w_word_idx];
  assign w_rd_byte = w_rd_word[{w_offset[1:0], 3'b000} +: 8];
  assign w_rd_half = w_offset[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load_data = w_rd_word;
    case (bus.Funct3_i)
      F3_B:    w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
      F3_BU:   w_load_data = {24'b0, w_rd_byte};
      F3_H:    w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
      F3_HU:   w_load_data = {16'b0, w_rd_half};
      default: w_load_data = w_rd_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_resp_valid = (r_state == S_RESP);
    w_req_ready  = ~w_resp_valid | bus.Resp_Ready_i;
    w_accept     = bus.Req_Valid_i & w_req_ready;
    w_capture    = w_accept & ~bus.Mem_Write_i;
    case (r_state)
      S_IDLE:  if (w_capture) w_state_next = S_RESP;
      S_RESP:  if (bus.Resp_Ready_i) w_state_next = w_capture ? S_RESP : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_store_en = w_accept & bus.Mem_Write_i & ~w_fault & ~reset;

  // NOTE: the storage array is deliberately not reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata       <= '0;
      r_resp_fault  <= 1'b0;
      r_store_fault <= 1'b0;
    end else begin
      r_store_fault <= w_accept & bus.Mem_Write_i & w_fault;
      if (w_capture) begin
        r_resp_fault <= w_fault;
        r_rdata      <= w_fault ? '0 : w_load_data;
      end
    end
  end

  assign bus.Req_Ready_o  = w_req_ready;
  assign bus.Resp_Valid_o = w_resp_valid;
  assign bus.Read_Data_o  = w_resp_valid ? r_rdata : '0;
  assign bus.Fault_o      = (w_resp_valid & r_resp_fault) | r_store_fault;

endmodule

// File: tb/tb_data_memory_subword.sv
// Directed bench for data_memory_subword: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares whenever the DUT presents one.
module tb_data_memory_subword;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 256;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic        is_load;
    int          tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   tag_ctr = 0;

  data_memory_subword_if bus();

  data_memory_subword #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_load, input logic [31:0] data, input logic fault);
    exp_t e;
    e.data    = data;
    e.fault   = fault;
    e.is_load = is_load;
    e.tag     = tag_ctr;
    tag_ctr++;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the request until it is accepted (bounded), then drops it.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] off,
                       input logic [31:0] wdata, input logic exp_resp,
                       input logic [31:0] exp_data, input logic exp_fault);
    if (exp_resp) push_exp(!wr, exp_data, exp_fault);
    bus.Req_Valid_i  = 1'b1;
    bus.Mem_Write_i  = wr;
    bus.Funct3_i     = f3;
    bus.Address_i    = BASE + off;
    bus.Write_Data_i = wdata;
    for (int w = 0; w <= 32; w++) begin
      @(negedge clk);
      if (bus.Req_Ready_o) break;
      if (w == 32) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: Req_Ready_o stayed %b for offset %h", bus.Req_Ready_o, off);
      end
    end
    step();
    bus.Req_Valid_i = 1'b0;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] off, input logic [31:0] wdata,
                    input logic fault);
    issue(1'b1, f3, off, wdata, fault, 32'h0, fault);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] off, input logic [31:0] exp_data,
                    input logic fault);
    issue(1'b0, f3, off, 32'h0, 1'b1, exp_data, fault);
  endtask

  always @(negedge clk) begin
    if (!reset && ((bus.Resp_Valid_o && bus.Resp_Ready_i) || (!bus.Resp_Valid_o && bus.Fault_o))) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_response: valid=%b fault=%b data=%h with nothing expected",
                 bus.Resp_Valid_o, bus.Fault_o, bus.Read_Data_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_load !== bus.Resp_Valid_o || mon_e.fault !== bus.Fault_o ||
            mon_e.data !== bus.Read_Data_o) begin
          n_err++;
          $display("FAIL resp_%0d: got valid=%b fault=%b data=%h expected valid=%b fault=%b data=%h",
                   mon_e.tag, bus.Resp_Valid_o, bus.Fault_o, bus.Read_Data_o,
                   mon_e.is_load, mon_e.fault, mon_e.data);
        end
      end
    end
  end

  initial begin
    bus.Req_Valid_i  = 1'b0;
    bus.Mem_Write_i  = 1'b0;
    bus.Funct3_i     = F_W;
    bus.Address_i    = BASE;
    bus.Write_Data_i = 32'h0;
    bus.Resp_Ready_i = 1'b1;
    reset            = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_resp_valid", {31'b0, bus.Resp_Valid_o}, 32'd0);
    check("reset_req_ready",  {31'b0, bus.Req_Ready_o},  32'd1);
    check("reset_fault",      {31'b0, bus.Fault_o},      32'd0);
    check("reset_read_data",  bus.Read_Data_o,           32'h0);
    step();
    reset = 1'b0;

    // Word store then back-to-back word load; response the cycle after accept.
    st(F_W, 32'h4, 32'hDEAD_BEEF, 1'b0);
    ld(F_W, 32'h4, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("load_latency", {31'b0, bus.Resp_Valid_o}, 32'd1);
    step();

    // Byte store uses only the low byte; signed/unsigned byte loads.
    st(F_B,  32'h5, 32'hAAAA_AA80, 1'b0);
    ld(F_B,  32'h5, 32'hFFFF_FF80, 1'b0);
    ld(F_BU, 32'h5, 32'h0000_0080, 1'b0);
    ld(F_W,  32'h4, 32'hDEAD_80EF, 1'b0);

    // Halfword store and loads, including a misaligned halfword.
    st(F_H,  32'h6, 32'h5555_1234, 1'b0);
    ld(F_H,  32'h6, 32'h0000_1234, 1'b0);
    ld(F_H,  32'h5, 32'h0000_0000, 1'b1);
    ld(F_HU, 32'h4, 32'h0000_80EF, 1'b0);
    ld(F_H,  32'h4, 32'hFFFF_80EF, 1'b0);
    ld(F_W,  32'h4, 32'h1234_80EF, 1'b0);

    // Range, alignment and funct3 faults; faulting stores leave RAM untouched.
    st(F_W,  32'h0,        32'h1111_1111, 1'b0);
    st(F_W,  32'h400,      32'hFFFF_FFFF, 1'b1);
    ld(F_W,  32'h0,        32'h1111_1111, 1'b0);
    ld(F_W,  32'hFFFF_FFFC, 32'h0,        1'b1);
    st(F_W,  32'h2,        32'h2222_2222, 1'b1);
    st(F_BU, 32'h0,        32'h0000_0033, 1'b1);
    ld(3'b011, 32'h0,      32'h0,         1'b1);
    ld(F_W,  32'h0,        32'h1111_1111, 1'b0);
    st(F_W,  32'h3FC,      32'hCAFE_F00D, 1'b0);
    ld(F_W,  32'h3FC,      32'hCAFE_F00D, 1'b0);
    ld(F_B,  32'h3FF,      32'hFFFF_FFCA, 1'b0);
    ld(F_B,  32'h400,      32'h0,         1'b1);
    step();
    @(negedge clk);
    check("idle_resp_valid", {31'b0, bus.Resp_Valid_o}, 32'd0);
    check("idle_read_data",  bus.Read_Data_o,           32'h0);
    step();

    // Three loads on consecutive cycles with the consumer stalling on the second response.
    push_exp(1'b1, 32'h1234_80EF, 1'b0);
    bus.Req_Valid_i = 1'b1; bus.Mem_Write_i = 1'b0; bus.Funct3_i = F_W; bus.Address_i = BASE + 32'h4;
    step();
    push_exp(1'b1, 32'h1111_1111, 1'b0);
    bus.Address_i = BASE + 32'h0;
    step();
    push_exp(1'b1, 32'hCAFE_F00D, 1'b0);
    bus.Address_i    = BASE + 32'h3FC;
    bus.Resp_Ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_req_ready",  {31'b0, bus.Req_Ready_o},  32'd0);
      check("stall_resp_valid", {31'b0, bus.Resp_Valid_o}, 32'd1);
      check("stall_held_data",  bus.Read_Data_o,           32'h1111_1111);
      step();
    end
    bus.Resp_Ready_i = 1'b1;
    @(negedge clk);
    check("release_req_ready", {31'b0, bus.Req_Ready_o}, 32'd1);
    step();
    bus.Req_Valid_i = 1'b0;
    step();

    // Reset while a response is pending drops it; stored data survives.
    bus.Resp_Ready_i = 1'b0;
    bus.Req_Valid_i = 1'b1; bus.Mem_Write_i = 1'b0; bus.Funct3_i = F_W; bus.Address_i = BASE + 32'h4;
    step();
    bus.Req_Valid_i = 1'b0;
    @(negedge clk);
    check("pending_before_reset", {31'b0, bus.Resp_Valid_o}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_resp_valid", {31'b0, bus.Resp_Valid_o}, 32'd0);
    check("post_reset_req_ready",  {31'b0, bus.Req_Ready_o},  32'd1);
    check("post_reset_read_data",  bus.Read_Data_o,           32'h0);
    check("post_reset_fault",      {31'b0, bus.Fault_o},      32'd0);
    step();
    bus.Resp_Ready_i = 1'b1;
    ld(F_W, 32'h4,   32'h1234_80EF, 1'b0);
    ld(F_W, 32'h3FC, 32'hCAFE_F00D, 1'b0);

    repeat (3) step();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
